// File: rtl/alsu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alsu_pkg : shared ALSU opcode, command and response types   (rev 1.0)
// ----------------------------------------------------------------------------
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_OR       = 3'd0,
    OP_XOR      = 3'd1,
    OP_ADD      = 3'd2,
    OP_MULT     = 3'd3,
    OP_SHIFT    = 3'd4,
    OP_ROTATE   = 3'd5,
    OP_INVALID6 = 3'd6,
    OP_INVALID7 = 3'd7
  } opcode_e;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    opcode_e    opcode;
    logic       cin;
    logic       serial_in;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
    logic       direction;
  } cmd_t;

  typedef struct packed {
    opcode_e     opcode;
    logic [15:0] leds;
    logic [5:0]  result;
  } rsp_t;

  localparam int unsigned CMD_W = $bits(cmd_t);
  localparam int unsigned RSP_W = $bits(rsp_t);

  function automatic logic [6:0] ctrl_bits(input cmd_t c);
    return {c.cin, c.serial_in, c.red_op_a, c.red_op_b, c.bypass_a, c.bypass_b, c.direction};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_cmd_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alsu_cmd_sequencer_if : command/response handshake bundle   (rev 1.0)
// ----------------------------------------------------------------------------
interface alsu_cmd_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [5:0]  rsp_out;
  logic [15:0] rsp_leds;
  logic [2:0]  rsp_opcode;

  modport master (
    output cmd_valid, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_opcode
  );

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_out, rsp_leds, rsp_opcode
  );

endinterface
`default_nettype wire

// File: rtl/alsu_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alsu_sync_fifo : single-clock FIFO with full/empty/count flags   (rev 1.0)
// ----------------------------------------------------------------------------
module alsu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_wr;
  logic             do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write into a full FIFO is honoured only when the head leaves in the same cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/alsu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alsu_cmd_sequencer : credit-based command issue to an ALSU with ordered responses   (rev 1.0)
// ----------------------------------------------------------------------------
module alsu_cmd_sequencer
  import alsu_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned ALSU_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alsu_cmd_sequencer_if.slave        bus,
  output logic [2:0]                 alsu_a_o,
  output logic [2:0]                 alsu_b_o,
  output logic [2:0]                 alsu_opcode_o,
  output logic [6:0]                 alsu_ctrl_o,
  input  logic [5:0]                 alsu_out_i,
  input  logic [15:0]                alsu_leds_i,
  output logic [15:0]                issued_cnt_o
);

  localparam int unsigned CAW = $clog2(CMD_DEPTH);
  localparam int unsigned RAW = $clog2(RSP_DEPTH);
  localparam int unsigned CRW = $clog2(RSP_DEPTH + ALSU_LAT + 1);

  logic                ready_q;
  logic                cmd_full;
  logic                cmd_empty;
  logic [CAW:0]        cmd_count;
  cmd_t                cmd_head;
  logic                accept;

  logic                rsp_full;
  logic                rsp_empty;
  logic [RAW:0]        rsp_count;
  rsp_t                rsp_head;
  rsp_t                rsp_push;

  logic                issue;
  logic                capture;
  logic [CRW-1:0]      credit_used;
  logic [CRW-1:0]      inflight_q;
  logic [CRW-1:0]      inflight_d;
  logic [ALSU_LAT-1:0] vld_q;
  opcode_e             op_q [ALSU_LAT];
  cmd_t                alsu_q;
  cmd_t                alsu_d;
  logic [15:0]         issued_cnt_q;

  // ready_q keeps cmd_ready low until the first edge after reset release.
  assign bus.cmd_ready = ready_q && !cmd_full;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  alsu_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .wr_data_i (bus.cmd_data),
    .rd_en_i   (issue),
    .rd_data_o (cmd_head),
    .full_o    (cmd_full),
    .empty_o   (cmd_empty),
    .count_o   (cmd_count)
  );

  // Every result in flight already owns a response slot, so capture never overflows.
  assign capture     = vld_q[ALSU_LAT-1];
  assign credit_used = CRW'(rsp_count) + inflight_q;
  assign issue       = !cmd_empty && (credit_used < CRW'(RSP_DEPTH));

  always_comb begin
    rsp_push        = '0;
    rsp_push.opcode = op_q[ALSU_LAT-1];
    rsp_push.leds   = alsu_leds_i;
    rsp_push.result = alsu_out_i;
  end

  alsu_sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (capture),
    .wr_data_i (rsp_push),
    .rd_en_i   (bus.rsp_ready),
    .rd_data_o (rsp_head),
    .full_o    (rsp_full),
    .empty_o   (rsp_empty),
    .count_o   (rsp_count)
  );

  assign bus.rsp_valid  = !rsp_empty;
  assign bus.rsp_out    = rsp_head.result;
  assign bus.rsp_leds   = rsp_head.leds;
  assign bus.rsp_opcode = rsp_head.opcode;

  always_comb begin
    alsu_d     = '0;
    inflight_d = inflight_q;
    if (issue) alsu_d = cmd_head;
    case ({issue, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      alsu_q       <= '0;
      vld_q        <= '0;
      inflight_q   <= '0;
      issued_cnt_q <= '0;
      for (int i = 0; i < ALSU_LAT; i++) op_q[i] <= OP_OR;
    end else begin
      ready_q    <= 1'b1;
      alsu_q     <= alsu_d;
      inflight_q <= inflight_d;
      vld_q[0]   <= issue;
      op_q[0]    <= cmd_head.opcode;
      for (int i = 1; i < ALSU_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        op_q[i]  <= op_q[i-1];
      end
      if (issue) issued_cnt_q <= issued_cnt_q + 1'b1;
    end
  end

  assign alsu_a_o      = alsu_q.a;
  assign alsu_b_o      = alsu_q.b;
  assign alsu_opcode_o = alsu_q.opcode;
  assign alsu_ctrl_o   = ctrl_bits(alsu_q);
  assign issued_cnt_o  = issued_cnt_q;

  assert property (@(posedge clk) disable iff (!rst_n) cmd_empty == (cmd_count == '0));
  assert property (@(posedge clk) disable iff (!rst_n) capture |-> (!rsp_full || bus.rsp_ready));

endmodule
`default_nettype wire

// File: tb/tb_alsu_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alsu_cmd_sequencer : scoreboard bench with a one-stage behavioural ALSU   (rev 1.0)
// ----------------------------------------------------------------------------
module tb_alsu_cmd_sequencer;
  import alsu_pkg::*;

  localparam int unsigned TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  alsu_a;
  logic [2:0]  alsu_b;
  logic [2:0]  alsu_opcode;
  logic [6:0]  alsu_ctrl;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic [15:0] issued_cnt;

  int   total = 0;
  int   bad   = 0;
  rsp_t exp_q[$];
  rsp_t rsp_log[$];
  rsp_t mon_got;
  rsp_t mon_exp;

  always #5 clk = ~clk;

  alsu_cmd_sequencer_if bus ();

  alsu_cmd_sequencer #(
    .CMD_DEPTH (4),
    .RSP_DEPTH (4),
    .ALSU_LAT  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .alsu_a_o      (alsu_a),
    .alsu_b_o      (alsu_b),
    .alsu_opcode_o (alsu_opcode),
    .alsu_ctrl_o   (alsu_ctrl),
    .alsu_out_i    (alsu_out),
    .alsu_leds_i   (alsu_leds),
    .issued_cnt_o  (issued_cnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Returns {leds, result} for one ALSU operation.
  function automatic logic [21:0] alsu_model(input cmd_t c);
    logic [5:0]  x;
    logic [5:0]  r;
    logic [15:0] leds;
    x    = {3'b000, c.a};
    leds = '0;
    r    = '0;
    if (c.opcode == OP_INVALID6 || c.opcode == OP_INVALID7) begin
      leds = 16'hFFFF;
    end else if (c.bypass_a) begin
      r = {3'b000, c.a};
    end else if (c.bypass_b) begin
      r = {3'b000, c.b};
    end else begin
      case (c.opcode)
        OP_OR:     r = c.red_op_a ? {5'b0, |c.a} : c.red_op_b ? {5'b0, |c.b} : {3'b000, c.a | c.b};
        OP_XOR:    r = c.red_op_a ? {5'b0, ^c.a} : c.red_op_b ? {5'b0, ^c.b} : {3'b000, c.a ^ c.b};
        OP_ADD:    r = 6'(c.a) + 6'(c.b) + 6'(c.cin);
        OP_MULT:   r = 6'(c.a) * 6'(c.b);
        OP_SHIFT:  r = c.direction ? {x[4:0], c.serial_in} : {c.serial_in, x[5:1]};
        OP_ROTATE: r = c.direction ? {x[4:0], x[5]} : {x[0], x[5:1]};
        default:   r = '0;
      endcase
    end
    return {leds, r};
  endfunction

  function automatic rsp_t expect_rsp(input cmd_t c);
    rsp_t r;
    r = '0;
    {r.leds, r.result} = alsu_model(c);
    r.opcode = c.opcode;
    return r;
  endfunction

  function automatic cmd_t mk_cmd(input logic [2:0] a, input logic [2:0] b,
                                  input opcode_e op, input logic [6:0] ctrl);
    return cmd_t'({a, b, op, ctrl});
  endfunction

  function automatic cmd_t rand_cmd();
    return cmd_t'(16'($urandom));
  endfunction

  // Behavioural ALSU: one register stage, so together with the sequencer's
  // operand register the result is ready two cycles after issue.
  always @(posedge clk) begin
    {alsu_leds, alsu_out} <= alsu_model(cmd_t'({alsu_a, alsu_b, alsu_opcode, alsu_ctrl}));
  end

  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      mon_got        = '0;
      mon_got.opcode = opcode_e'(bus.rsp_opcode);
      mon_got.leds   = bus.rsp_leds;
      mon_got.result = bus.rsp_out;
      rsp_log.push_back(mon_got);
      check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("rsp_out",    32'(mon_got.result), 32'(mon_exp.result));
        check("rsp_leds",   32'(mon_got.leds),   32'(mon_exp.leds));
        check("rsp_opcode", 32'(mon_got.opcode), 32'(mon_exp.opcode));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_cmd(input cmd_t c, output int unsigned waits);
    waits         = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    while (bus.cmd_ready !== 1'b1 && waits < TIMEOUT) begin
      @(negedge clk);
      waits++;
    end
    if (bus.cmd_ready !== 1'b1) check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    else exp_q.push_back(expect_rsp(c));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int unsigned cyc;
    cyc = 0;
    while (rsp_log.size() < n && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check("rsp_count", 32'(rsp_log.size()), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    int unsigned waits_total;
    logic [15:0] base;
    int          log_base;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("rst_cmd_ready",  32'(bus.cmd_ready), 32'd0);
    check("rst_issued",     32'(issued_cnt),    32'd0);
    check("rst_alsu_op",    32'(alsu_opcode),   32'd0);
    check("rst_alsu_a",     32'(alsu_a),        32'd0);
    check("rst_alsu_ctrl",  32'(alsu_ctrl),     32'd0);

    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge",  32'(bus.cmd_ready), 32'd1);

    // Single ADD and first-response latency.
    bus.rsp_ready = 1'b1;
    send_cmd(mk_cmd(3'd3, 3'd2, OP_ADD, 7'b1000000), w);
    repeat (2) @(negedge clk);
    check("add_latency_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("add_latency",       32'(bus.rsp_valid), 32'd1);
    check("add_issued",        32'(issued_cnt),    32'd1);
    wait_rsp(1);
    check("add_out",    32'(rsp_log[0].result), 32'd6);
    check("add_opcode", 32'(rsp_log[0].opcode), 32'd2);
    check("add_leds",   32'(rsp_log[0].leds),   32'd0);

    // Invalid opcode followed by OR.
    send_cmd(mk_cmd(3'd0, 3'd0, OP_INVALID6, 7'b0000000), w);
    send_cmd(mk_cmd(3'd1, 3'd4, OP_OR,       7'b0000000), w);
    wait_rsp(3);
    check("inv_out",  32'(rsp_log[1].result), 32'd0);
    check("inv_leds", 32'(rsp_log[1].leds),   32'hFFFF);
    check("or_out",   32'(rsp_log[2].result), 32'd5);

    // Bypass A takes priority over bypass B.
    send_cmd(mk_cmd(3'd5, 3'd2, OP_ADD, 7'b0000110), w);
    wait_rsp(4);
    check("bypass_out", 32'(rsp_log[3].result), 32'd5);

    // Burst with the consumer stalled: credits cap issue at the response depth.
    bus.rsp_ready = 1'b0;
    base = issued_cnt;
    for (int i = 0; i < 8; i++) send_cmd(rand_cmd(), w);
    repeat (4) @(negedge clk);
    check("burst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("burst_issued",    32'(16'(issued_cnt - base)), 32'd4);
    check("burst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("burst_held",      32'(rsp_log.size()), 32'd4);
    check("burst_idle_op",   32'(alsu_opcode), 32'd0);
    check("burst_idle_ctrl", 32'(alsu_ctrl),   32'd0);
    bus.rsp_ready = 1'b1;
    wait_rsp(12);
    check("burst_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three buffered responses, one in flight and two queued.
    bus.rsp_ready = 1'b0;
    base = issued_cnt;
    for (int i = 0; i < 3; i++) send_cmd(rand_cmd(), w);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) send_cmd(rand_cmd(), w);
    check("pre_rst_issued", 32'(16'(issued_cnt - base)), 32'd4);
    log_base = rsp_log.size();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_issued",    32'(issued_cnt),    32'd0);
    check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_no_rsp",  32'(rsp_log.size()), 32'(log_base));
    check("post_rst_issued",  32'(issued_cnt),     32'd0);
    check("post_rst_ready",   32'(bus.cmd_ready),  32'd1);

    // Continuous stream: one command per cycle with no back-pressure.
    waits_total = 0;
    log_base    = rsp_log.size();
    for (int i = 0; i < 20; i++) begin
      send_cmd(rand_cmd(), w);
      waits_total += w;
    end
    wait_rsp(log_base + 20);
    check("stream_issued",   32'(issued_cnt),   32'd20);
    check("stream_stalls",   32'(waits_total),  32'd0);
    check("stream_drained",  32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
